// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch sequencer.
package fetch_pkg;

    localparam int unsigned PC_W    = 8;
    localparam int unsigned INSTR_W = 32;

    localparam logic [PC_W-1:0]    DEF_RESET_PC  = 8'h00;
    localparam int unsigned        DEF_PC_STEP   = 4;
    localparam logic [INSTR_W-1:0] DEF_HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } fetch_word_t;

    // Instructions are word aligned; drop the byte-offset bits.
    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
        return {pc[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding buffer for a returned fetch word that the consumer could not take.
module fetch_skid_buf
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        wr_en,
    input  fetch_word_t wr_word,
    input  logic        rd_en,
    output logic        valid,
    output fetch_word_t word
);

    logic        valid_q;
    logic        valid_d;
    fetch_word_t word_q;
    fetch_word_t word_d;

    // A write in the same cycle as a read replaces the drained entry; flush wins.
    always_comb begin
        valid_d = valid_q;
        word_d  = word_q;
        if (rd_en) begin
            valid_d = 1'b0;
        end
        if (wr_en) begin
            valid_d = 1'b1;
            word_d  = wr_word;
        end
        if (flush) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            word_q  <= '0;
        end else begin
            valid_q <= valid_d;
            word_q  <= word_d;
        end
    end

    assign valid = valid_q;
    assign word  = word_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, tracks one in-flight read, buffers one
// returned word, squashes on redirect and stops on the halt instruction.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0]    RESET_PC  = DEF_RESET_PC,
    parameter logic [PC_W-1:0]    PC_STEP   = PC_W'(DEF_PC_STEP),
    parameter logic [INSTR_W-1:0] HALT_WORD = DEF_HALT_WORD
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    output logic [PC_W-1:0]    imem_pc,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic               halted
);

    fetch_state_e    state_q;
    fetch_state_e    state_d;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic [PC_W-1:0] req_pc_q;
    logic [PC_W-1:0] req_pc_d;
    logic            inflight_q;
    logic            inflight_d;

    logic            resp;
    logic            skid_valid;
    fetch_word_t     skid_word;
    fetch_word_t     resp_word;
    logic            skid_wr;
    logic            skid_rd;
    logic            skid_flush;
    logic            skid_next;
    logic            xfer;
    logic            halt_xfer;
    logic            issue;

    assign resp      = inflight_q;
    assign resp_word = '{instr: imem_instr, pc: req_pc_q};

    // The skid entry is always older than the memory response, so it goes first.
    always_comb begin
        out_valid = (skid_valid | resp) & ~redirect_valid;
        out_instr = '0;
        out_pc    = '0;
        if (skid_valid) begin
            out_instr = skid_word.instr;
            out_pc    = skid_word.pc;
        end else if (resp) begin
            out_instr = resp_word.instr;
            out_pc    = resp_word.pc;
        end
    end

    assign xfer       = out_valid & out_ready;
    assign halt_xfer  = xfer & (out_instr == HALT_WORD);
    assign skid_wr    = resp & (skid_valid | ~out_ready);
    assign skid_rd    = skid_valid & out_ready;
    assign skid_flush = redirect_valid | halt_xfer;
    assign skid_next  = (skid_valid & (~out_ready | resp)) |
                        (~skid_valid & resp & ~out_ready);

    // Only issue when the returning word is guaranteed a home next cycle.
    assign issue = (state_q == FETCH) & run & ~redirect_valid & ~skid_next & ~halt_xfer;

    fetch_skid_buf u_skid (
        .clk     (clk),
        .rst     (rst),
        .flush   (skid_flush),
        .wr_en   (skid_wr),
        .wr_word (resp_word),
        .rd_en   (skid_rd),
        .valid   (skid_valid),
        .word    (skid_word)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = issue;

        if (issue) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + PC_STEP;
        end

        case (state_q)
            IDLE:    if (run) state_d = FETCH;
            FETCH:   if (!run) state_d = IDLE;
            HALTED:  if (redirect_valid) state_d = run ? FETCH : IDLE;
            default: state_d = IDLE;
        endcase

        // A delivered halt stops fetch even if it drained after run dropped.
        if (halt_xfer) begin
            state_d    = HALTED;
            inflight_d = 1'b0;
        end

        if (redirect_valid) begin
            pc_d       = align_pc(redirect_pc);
            inflight_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
        end
    end

    assign imem_pc = pc_q;
    assign halted  = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a queue-based reference model.
module tb_fetch_ctrl;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
    localparam int M_IDLE  = 0;
    localparam int M_FETCH = 1;
    localparam int M_HALT  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [7:0]  imem_pc;
    logic [31:0] imem_instr = 32'h0;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [7:0]  out_pc;
    logic        halted;

    int n_chk = 0;
    int n_err = 0;
    logic chk_en = 1'b0;

    logic [31:0] mem [64];

    typedef struct packed {
        logic [31:0] instr;
        logic [7:0]  pc;
    } mw_t;

    // Reference model: words fetched but not yet delivered, plus PC and run mode.
    mw_t        m_q[$];
    logic [7:0] m_pc   = 8'h00;
    int         m_mode = M_IDLE;

    fetch_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .run            (run),
        .imem_pc        (imem_pc),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) imem_instr <= mem[imem_pc[7:2]];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_eval(output logic v, output mw_t w, output logic x,
                                       output logic hx, output logic iss);
        int rem;
        v   = (m_q.size() > 0) && !redirect_valid;
        w   = (m_q.size() > 0) ? m_q[0] : '0;
        x   = v && out_ready;
        hx  = x && (w.instr == HALT);
        rem = m_q.size() - (x ? 1 : 0);
        iss = (m_mode == M_FETCH) && run && !redirect_valid && (rem == 0) && !hx;
    endfunction

    always @(posedge clk) begin
        logic v, x, hx, iss;
        mw_t  w;
        model_eval(v, w, x, hx, iss);
        if (rst) begin
            m_q.delete();
            m_pc   = 8'h00;
            m_mode = M_IDLE;
        end else begin
            if (x) void'(m_q.pop_front());
            if (redirect_valid) m_q.delete();
            if (hx) m_q.delete();
            if (iss) begin
                m_q.push_back('{instr: mem[m_pc[7:2]], pc: m_pc});
                m_pc = m_pc + 8'd4;
            end
            if (redirect_valid) m_pc = {redirect_pc[7:2], 2'b00};
            case (m_mode)
                M_IDLE:  if (run) m_mode = M_FETCH;
                M_FETCH: if (!run) m_mode = M_IDLE;
                default: if (redirect_valid) m_mode = run ? M_FETCH : M_IDLE;
            endcase
            if (hx) m_mode = M_HALT;
        end
    end

    always @(negedge clk) begin
        logic v, x, hx, iss;
        mw_t  w;
        #2;
        if (chk_en) begin
            model_eval(v, w, x, hx, iss);
            check("out_valid", 32'(out_valid), 32'(v));
            check("imem_pc", 32'(imem_pc), 32'(m_pc));
            check("halted", 32'(halted), 32'(m_mode == M_HALT));
            if (v) begin
                check("out_pc", 32'(out_pc), 32'(w.pc));
                check("out_instr", out_instr, w.instr);
            end
        end
    end

    task automatic drive(input logic r, input logic rn, input logic rdy,
                         input logic rv, input logic [7:0] rp);
        @(negedge clk);
        rst            = r;
        run            = rn;
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rp;
    endtask

    task automatic expect_word(input string nm, input logic [7:0] pc, input logic [31:0] instr);
        #3;
        check({nm, "_valid"}, 32'(out_valid), 32'd1);
        check({nm, "_pc"}, 32'(out_pc), 32'(pc));
        check({nm, "_instr"}, out_instr, instr);
    endtask

    task automatic expect_idle(input string nm, input logic hlt);
        #3;
        check({nm, "_valid"}, 32'(out_valid), 32'd0);
        check({nm, "_halted"}, 32'(halted), 32'(hlt));
    endtask

    logic [7:0] a_pc  [8];
    logic       a_rdy [8];

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 | 32'(i * 4);
        a_pc  = '{8'h00, 8'h04, 8'h08, 8'h08, 8'h08, 8'h08, 8'h0C, 8'h10};
        a_rdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        rst = 1'b1; run = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 8'h00;

        // Reset state
        drive(1, 0, 1, 0, 8'h00);
        drive(1, 0, 1, 0, 8'h00);
        chk_en = 1'b1;
        #3;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_imem_pc", 32'(imem_pc), 32'h00);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_out_pc", 32'(out_pc), 32'h00);

        // Start-up latency, sequential stream and a 3-cycle stall at 0x08
        drive(0, 1, 1, 0, 8'h00); expect_idle("lat0", 1'b0);
        drive(0, 1, 1, 0, 8'h00); expect_idle("lat1", 1'b0);
        for (int i = 0; i < 8; i++) begin
            drive(0, 1, a_rdy[i], 0, 8'h00);
            expect_word("seq", a_pc[i], 32'hC0DE_0000 | 32'(a_pc[i]));
        end

        // Redirect to 0x43 while the skid holds 0x14
        drive(0, 1, 0, 0, 8'h00); expect_word("skid", 8'h14, 32'hC0DE_0014);
        drive(0, 1, 0, 1, 8'h43); expect_idle("redir0", 1'b0);
        drive(0, 1, 1, 0, 8'h00); expect_idle("redir1", 1'b0);
        drive(0, 1, 1, 0, 8'h00); expect_word("redir2", 8'h40, 32'hC0DE_0040);
        drive(0, 1, 1, 0, 8'h00); expect_word("redir3", 8'h44, 32'hC0DE_0044);

        // PC wrap from 0xF8
        drive(0, 1, 1, 1, 8'hF8); expect_idle("wrap0", 1'b0);
        drive(0, 1, 1, 0, 8'h00); expect_idle("wrap1", 1'b0);
        drive(0, 1, 1, 0, 8'h00); expect_word("wrapF8", 8'hF8, 32'hC0DE_00F8);
        drive(0, 1, 1, 0, 8'h00); expect_word("wrapFC", 8'hFC, 32'hC0DE_00FC);
        drive(0, 1, 1, 0, 8'h00); expect_word("wrap00", 8'h00, 32'hC0DE_0000);

        // Halt word at 0x10, then redirect to 0x20 resumes
        mem[4] = HALT;
        drive(0, 1, 1, 1, 8'h08); expect_idle("h0", 1'b0);
        drive(0, 1, 1, 0, 8'h00); expect_idle("h1", 1'b0);
        drive(0, 1, 1, 0, 8'h00); expect_word("h08", 8'h08, 32'hC0DE_0008);
        drive(0, 1, 1, 0, 8'h00); expect_word("h0C", 8'h0C, 32'hC0DE_000C);
        drive(0, 1, 1, 0, 8'h00); expect_word("h10", 8'h10, HALT);
        drive(0, 1, 1, 0, 8'h00); expect_idle("hstop0", 1'b1);
        drive(0, 1, 1, 0, 8'h00); expect_idle("hstop1", 1'b1);
        drive(0, 1, 1, 1, 8'h20); expect_idle("hredir", 1'b1);
        drive(0, 1, 1, 0, 8'h00); expect_idle("hresume", 1'b0);
        drive(0, 1, 1, 0, 8'h00); expect_word("h20", 8'h20, 32'hC0DE_0020);
        mem[4] = 32'hC0DE_0010;

        // Reset while a word is held
        drive(0, 1, 0, 0, 8'h00); expect_word("hold", 8'h24, 32'hC0DE_0024);
        drive(1, 1, 0, 0, 8'h00); expect_word("hold_rst", 8'h24, 32'hC0DE_0024);
        drive(0, 0, 1, 0, 8'h00);
        #3;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_imem_pc", 32'(imem_pc), 32'h00);
        check("midrst_halted", 32'(halted), 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 64; i++)
            mem[i] = ($urandom_range(0, 15) == 0) ? HALT : $urandom;
        for (int c = 0; c < 3000; c++) begin
            drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 11) == 0),
                  8'($urandom));
        end

        drive(0, 0, 1, 0, 8'h00);
        #3;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer in front of the byte-addressed instruction memory, which has a registered 1-cycle read. It owns the program counter and issues one fetch address per cycle. It tracks the single in-flight read and buffers one returned word so downstream stalls never lose an instruction. It also handles branch redirects by squashing stale reads and stops fetching on a halt sentinel.

## Interface
- PC_W, 8, width of the PC and memory address
- INSTR_W, 32, instruction width
- RESET_PC, 8'h00, PC loaded on reset
- PC_STEP, 4, byte increment per sequential fetch
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetch
- clk  in  1  single clock; everything is updated on the posedge
- rst  in  1  reset; synchronous and active-high
- run  in  1  fetch enable
- imem_pc  out  PC_W  address to the instruction memory; equals the internal pc_q at all times
- imem_instr  in  INSTR_W  memory data for the address sampled on the previous edge
- redirect_valid  in  1  branch/jump redirect strobe
- redirect_pc  in  PC_W  redirect target; bits [1:0] are forced to 0
- out_valid  out  1  instruction available
- out_ready  in  1  consumer accepts the instruction
- out_instr  out  INSTR_W  fetched instruction
- out_pc  out  PC_W  byte address of out_instr
- halted  out  1  HALT_WORD has been delivered and fetch is stopped

## Operation
- The FSM has three states.
  - IDLE: no issue; goes to FETCH when run=1.
  - FETCH: issues per the rule below; goes to IDLE when run=0; goes to HALTED on a HALT_WORD transfer.
  - HALTED: no issue; leaves only on redirect (to FETCH if run=1, otherwise IDLE) or on rst.
- resp = inflight_q. Valid data is present on imem_instr this cycle, and its address is req_pc_q.
- Output select: if skid_valid, out = skid; otherwise out = resp. out_valid = (skid_valid | resp) & !redirect_valid.
- A transfer occurs when out_valid & out_ready.
- Skid fill: if resp is not consumed this cycle, it is written into the skid. This covers two cases: the skid was outputting, or out_ready=0.
- skid_next = (skid_valid & (!out_ready | resp)) | (!skid_valid & resp & !out_ready).
- Issue = state==FETCH & run & !redirect_valid & !skid_next.
  - On issue: inflight_q<=1, req_pc_q<=pc_q, pc_q<=pc_q+PC_STEP.
  - With no issue: inflight_q<=0.
- PC arithmetic is modulo 2^PC_W, so 0xFC+4 wraps to 0x00.
- Redirect has priority over everything else:
  - pc_q <= {redirect_pc[PC_W-1:2],2'b00}
  - inflight_q <= 0, and skid_valid <= 0
  - no transfer in that cycle
  - it exits HALTED
- HALT_WORD handling: the halt instruction itself is transferred. After it, no further issue, and any in-flight response is discarded.
- run=0 mid-stream: issue stops. An in-flight or skid entry is still delivered.

## Timing
- Reset values: pc_q=RESET_PC, imem_pc=RESET_PC, state=IDLE, inflight_q=0, skid_valid=0, skid data/pc=0, out_valid=0, halted=0, out_instr=0, out_pc=0.
- Fetch latency: issue at edge k, then out_valid during cycle k+1.
- Sustained throughput is 1 instruction/cycle while out_ready=1.
- Redirect sampled at edge k:
  - first issue of the target at edge k+1
  - out_valid at k+2
  - the stale read from edge k is dropped
- Stall: at most 1 word is in flight and at most 1 is held in the skid. Nothing is lost or duplicated.
- out_valid=1 with out_ready=0 keeps out_instr/out_pc stable until the transfer.
- rst mid-operation: all state is cleared on that edge, and out_valid=0 in the following cycle.

## Structure
- Shared package fetch_pkg holds:
  - the state enum (IDLE, FETCH, HALTED)
  - PC_STEP and HALT_WORD defaults
  - a fetch_word_t struct {instr, pc}
- One natural sub-module: fetch_skid_buf. It is a 1-entry skid buffer with valid/ready, flush input, and fetch_word_t payload.

## Test plan
- Reset, then run=1 with out_ready=1 and memory preloaded sequentially → out_pc = 0x00, 0x04, 0x08 on consecutive cycles; first out_valid 2 cycles after run rises.
- out_ready=0 for 3 cycles mid-stream at out_pc=0x08 → out_pc holds 0x08. After release, 0x0C and 0x10 follow back-to-back with no gap, loss or repeat.
- redirect_valid with redirect_pc=0x43 while a word is in flight and the skid is full → stale words are never shown; next out_pc=0x40 two cycles later.
- Sequential run from 0xF8 → out_pc sequence 0xF8, 0xFC, 0x00.
- Word at 0x10 = 32'hFFFF_FFFF → 0x10 is delivered, halted=1, no further out_valid. Redirect to 0x20 clears halted and resumes at 0x20.
- rst asserted while out_valid=1 and out_ready=0 → next cycle out_valid=0, imem_pc=RESET_PC, halted=0.
